// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit.
// Holds the prediction record carried from IF to EX.
package bru_pkg;

  localparam int BRU_XLEN = 32;
  localparam int PC_STEP  = 4;

  typedef struct packed {
    logic [BRU_XLEN-1:0] pc;
    logic                pred_taken;
    logic [BRU_XLEN-1:0] pred_target;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// IF push, EX resolve and predictor-update bundle.
// master drives pushes/resolves, slave is the resolve unit.
interface bru_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
);
  logic                     push_valid;
  logic [XLEN-1:0]          push_pc;
  logic                     push_pred_taken;
  logic [XLEN-1:0]          push_pred_target;
  logic                     push_ready;
  logic                     resolve_valid;
  logic [XLEN-1:0]          resolve_pc;
  logic                     resolve_taken;
  logic [XLEN-1:0]          resolve_target;
  logic                     ext_flush;
  logic                     flush;
  logic [XLEN-1:0]          redirect_pc;
  logic                     upd_valid;
  logic                     upd_taken;
  logic [$clog2(DEPTH):0]   occupancy;
  logic [CNT_W-1:0]         branch_cnt;
  logic [CNT_W-1:0]         mispred_cnt;
  logic                     err;

  modport master (
    output push_valid, push_pc, push_pred_taken,
    output push_pred_target,
    output resolve_valid, resolve_pc, resolve_taken,
    output resolve_target, ext_flush,
    input  push_ready, flush, redirect_pc,
    input  upd_valid, upd_taken, occupancy,
    input  branch_cnt, mispred_cnt, err
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken,
    input  push_pred_target,
    input  resolve_valid, resolve_pc, resolve_taken,
    input  resolve_target, ext_flush,
    output push_ready, flush, redirect_pc,
    output upd_valid, upd_taken, occupancy,
    output branch_cnt, mispred_cnt, err
  );
endinterface

// File: rtl/bru_pred_fifo.sv
// In-flight prediction queue, oldest entry at head.
// Clear wins over push and pop in the same cycle.
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  pred_entry_t            i_wdata,
  output pred_entry_t            o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  pred_entry_t      r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;

  assign o_rdata = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear)
      r_mem[r_wr] <= i_wdata;
  end

  // Pointer and count update; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push)
        r_wr <= r_wr + 1'b1;
      if (i_pop)
        r_rd <= r_rd + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Checks fetch predictions against EX outcomes.
// Drives flush/redirect, predictor update and counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN  = BRU_XLEN,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  bru_if.slave bus
);
  pred_entry_t            w_wdata;
  pred_entry_t            w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_mis;
  logic                   w_clear;
  logic                   w_err_set;
  logic [XLEN-1:0]        w_redir;

  logic                   r_flush;
  logic [XLEN-1:0]        r_redirect;
  logic                   r_upd_valid;
  logic                   r_upd_taken;
  logic [CNT_W-1:0]       r_branch_cnt;
  logic [CNT_W-1:0]       r_mispred_cnt;
  logic                   r_err;

  // Next-cycle effects of this cycle's push/resolve.
  always_comb begin
    w_wdata.pc          = bus.push_pc;
    w_wdata.pred_taken  = bus.push_pred_taken;
    w_wdata.pred_target = bus.push_pred_target;
    w_push  = bus.push_valid && !w_full;
    w_pop   = bus.resolve_valid && !w_empty;
    w_mis   = w_pop &&
              ((w_head.pred_taken != bus.resolve_taken) ||
               (bus.resolve_taken &&
                (w_head.pred_target != bus.resolve_target)));
    w_clear = w_mis || bus.ext_flush;
    w_err_set = (bus.push_valid && w_full) ||
                (bus.resolve_valid && w_empty) ||
                (w_pop && (w_head.pc != bus.resolve_pc));
    w_redir = bus.resolve_taken ? bus.resolve_target
                                : bus.resolve_pc + XLEN'(PC_STEP);
  end

  bru_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Registered flush/update pulses, counters, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush       <= 1'b0;
      r_redirect    <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_taken   <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      r_err         <= 1'b0;
    end else begin
      r_flush     <= w_mis && !bus.ext_flush;
      r_upd_valid <= w_pop;
      r_upd_taken <= w_pop && bus.resolve_taken;
      if (w_mis && !bus.ext_flush)
        r_redirect <= w_redir;
      if (w_pop)
        r_branch_cnt <= r_branch_cnt + 1'b1;
      if (w_mis)
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  assign bus.push_ready  = !w_full;
  assign bus.flush       = r_flush;
  assign bus.redirect_pc = r_redirect;
  assign bus.upd_valid   = r_upd_valid;
  assign bus.upd_taken   = r_upd_taken;
  assign bus.occupancy   = w_count;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;
  assign bus.err         = r_err;
endmodule
